// File: rtl/aes_pkg.sv
// Shared GF(2^8) helpers, MixColumns coefficients and FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Row-0 coefficient rows; row r uses the same row rotated right by r.
  localparam logic [0:3][7:0] FWD_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [0:3][7:0] INV_COEF = {8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Shift-and-add multiply; coefficient is a constant, so this folds to XORs.
  function automatic logic [7:0] gf_mul8(input logic [7:0] x, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = x;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// One-column forward/inverse MixColumns, purely combinational.
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [0:3][7:0] coef;

  assign coef = inv ? INV_COEF : FWD_COEF;

  // b_r = XOR_j coef[(j-r) mod 4] * a_j ; byte 0 sits in the top bits.
  always_comb begin
    col_out = '0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        col_out[31-8*r -: 8] = col_out[31-8*r -: 8]
                               ^ gf_mul8(col_in[31-8*j -: 8], coef[(j + 4 - r) % 4]);
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns: LANES columns per cycle over an NB-column state.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int NB    = 4,
  parameter int LANES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_inv,
  input  logic [32*NB-1:0] in_state,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] out_state,
  output logic            busy
);

  localparam int GROUPS = NB / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

  if (!((NB == 4 || NB == 6 || NB == 8) && (NB % LANES == 0))) begin : g_bad_param
    $error("mix_columns_iter: NB must be 4/6/8 and divisible by LANES");
  end

  // Ascending packed ranges make work[0][0] the most significant column,
  // so the flat view matches the port packing directly.
  logic [0:GROUPS-1][0:LANES-1][31:0] work;
  logic [0:LANES-1][31:0]             lane_out;
  logic [CW-1:0]                      cnt;
  logic                               inv_q;
  state_t                             state, nxt;
  logic                               accept;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mix_column_word u_mcw (
      .col_in  (work[cnt][l]),
      .inv     (inv_q),
      .col_out (lane_out[l])
    );
  end

  assign out_state = work;
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next state and handshake outputs; DONE can hand straight back to RUN.
  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          nxt    = RUN;
        end
      end
      RUN: if (cnt == LAST) nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept = 1'b1;
            nxt    = RUN;
          end else begin
            nxt = IDLE;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Working register, mode latch and group counter; transform in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      cnt   <= '0;
      inv_q <= 1'b0;
    end else if (accept) begin
      work  <= in_state;
      inv_q <= in_inv;
      cnt   <= '0;
    end else if (state == RUN) begin
      work[cnt] <= lane_out;
      if (cnt != LAST) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed and randomised checks of mix_columns_iter at NB=4/1, 6/2, 8/2.
module tb_mix_columns_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // NB=4, LANES=1
  logic         in_valid4 = 0, in_inv4 = 0, out_ready4 = 0;
  logic         in_ready4, out_valid4, busy4;
  logic [127:0] in_state4 = '0, out_state4;
  // NB=6 / NB=8, LANES=2, shared control
  logic         in_valid_w = 0, out_ready_w = 1;
  logic         in_ready6, out_valid6, busy6, in_ready8, out_valid8, busy8;
  logic [191:0] in_state6 = '0, out_state6;
  logic [255:0] in_state8 = '0, out_state8;

  mix_columns_iter #(.NB(4), .LANES(1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_inv(in_inv4), .in_state(in_state4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_state(out_state4), .busy(busy4));

  mix_columns_iter #(.NB(6), .LANES(2)) u6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready6),
    .in_inv(1'b0), .in_state(in_state6), .out_valid(out_valid6),
    .out_ready(out_ready_w), .out_state(out_state6), .busy(busy6));

  mix_columns_iter #(.NB(8), .LANES(2)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready8),
    .in_inv(1'b0), .in_state(in_state8), .out_valid(out_valid8),
    .out_ready(out_ready_w), .out_state(out_state8), .busy(busy8));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: explicit xtime chains per coefficient.
  function automatic logic [7:0] xt(input logic [7:0] x);
    return x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
  endfunction

  function automatic logic [7:0] m(input logic [7:0] x, input int c);
    logic [7:0] x2, x4, x8;
    x2 = xt(x); x4 = xt(x2); x8 = xt(x4);
    case (c)
      1:  return x;
      2:  return x2;
      3:  return x2 ^ x;
      9:  return x8 ^ x;
      11: return x8 ^ x2 ^ x;
      13: return x8 ^ x4 ^ x;
      default: return x8 ^ x4 ^ x2; // 14
    endcase
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] c, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    if (!inv)
      return {m(a0,2)^m(a1,3)^a2^a3, a0^m(a1,2)^m(a2,3)^a3,
              a0^a1^m(a2,2)^m(a3,3), m(a0,3)^a1^a2^m(a3,2)};
    return {m(a0,14)^m(a1,11)^m(a2,13)^m(a3,9), m(a0,9)^m(a1,14)^m(a2,11)^m(a3,13),
            m(a0,13)^m(a1,9)^m(a2,14)^m(a3,11), m(a0,11)^m(a1,13)^m(a2,9)^m(a3,14)};
  endfunction

  function automatic logic [127:0] ref4(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = ref_col(s[127-32*c -: 32], inv);
    return r;
  endfunction

  // Run one block on u4 from IDLE; hold = cycles of out_ready=0 in DONE.
  task automatic run4(input logic [127:0] st, input logic inv, input int hold,
                      output logic [127:0] res, output int lat);
    in_state4 = st; in_inv4 = inv; in_valid4 = 1;
    @(posedge clk); #1;
    in_valid4 = 0; in_inv4 = ~inv; in_state4 = '1;
    lat = 0;
    while (!out_valid4 && lat < 20) begin @(posedge clk); #1; lat++; end
    repeat (hold) begin @(posedge clk); #1; end
    res = out_state4; out_ready4 = 1;
    @(posedge clk); #1;
    out_ready4 = 0;
  endtask

  localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_d4d4d4d5_2d26314c;
  localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_d5d5d7d6_4d7ebdf8;

  initial begin
    logic [127:0] res, prev, st;
    logic         inv, stable, rdy_low;
    int           lat, lat6, lat8;
    logic [191:0] res6;
    logic [255:0] res8;

    // Reset state
    #1;
    chk("rst_in_ready", in_ready4, 1'b1);
    chk("rst_out_valid", out_valid4, 1'b0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_out_state", out_state4, '0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;

    // Forward, inverse, extra forward vectors
    run4(V1_IN, 1'b0, 0, res, lat);
    chk("fwd_v1", res, V1_OUT);
    chk("fwd_v1_latency", lat, 4);
    run4(V1_OUT, 1'b1, 0, res, lat);
    chk("inv_v1", res, V1_IN);
    run4(V2_IN, 1'b0, 0, res, lat);
    chk("fwd_v2", res, V2_OUT);
    run4(V2_OUT, 1'b1, 2, res, lat);
    chk("inv_v2", res, V2_IN);

    // Backpressure: hold DONE 10 cycles, then back-to-back accept
    in_state4 = V1_IN; in_inv4 = 0; in_valid4 = 1;
    @(posedge clk); #1; in_valid4 = 0;
    lat = 0;
    while (!out_valid4 && lat < 20) begin @(posedge clk); #1; lat++; end
    prev = out_state4; stable = 1; rdy_low = 1;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_state4 !== prev || out_valid4 !== 1'b1) stable = 0;
      if (in_ready4 !== 1'b0) rdy_low = 0;
    end
    chk("stall_stable", stable, 1'b1);
    chk("stall_in_ready_low", rdy_low, 1'b1);
    chk("stall_result", out_state4, V1_OUT);
    in_state4 = V1_OUT; in_inv4 = 1; in_valid4 = 1; out_ready4 = 1; #1;
    chk("b2b_in_ready", in_ready4, 1'b1);
    @(posedge clk); #1;
    in_valid4 = 0; out_ready4 = 0; in_inv4 = 0;
    chk("b2b_no_idle_busy", busy4, 1'b1);
    chk("b2b_out_valid_drop", out_valid4, 1'b0);
    lat = 0;
    while (!out_valid4 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("b2b_latency", lat, 4);
    chk("b2b_result", out_state4, V1_IN);
    out_ready4 = 1; @(posedge clk); #1; out_ready4 = 0;

    // Reset mid-RUN
    in_state4 = V2_IN; in_valid4 = 1;
    @(posedge clk); #1; in_valid4 = 0;
    @(posedge clk); #1;
    rst_n = 0; #1;
    chk("midrst_out_valid", out_valid4, 1'b0);
    chk("midrst_out_state", out_state4, '0);
    chk("midrst_in_ready", in_ready4, 1'b1);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    run4(V2_IN, 1'b0, 0, res, lat);
    chk("post_rst_result", res, V2_OUT);

    // Wide variants, both LANES=2
    in_state6 = {V1_IN, V2_IN[127:64]};
    in_state8 = {V1_IN, V2_IN[127:64], V1_IN[127:64]};
    in_valid_w = 1;
    @(posedge clk); #1; in_valid_w = 0;
    lat6 = -1; lat8 = -1; res6 = '0; res8 = '0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (out_valid6 && lat6 < 0) begin lat6 = cyc; res6 = out_state6; end
      if (out_valid8 && lat8 < 0) begin lat8 = cyc; res8 = out_state8; end
    end
    chk("nb6_latency", lat6, 3);
    chk("nb6_result", res6, {V1_OUT, V2_OUT[127:64]});
    chk("nb8_latency", lat8, 4);
    chk("nb8_result", res8, {V1_OUT, V2_OUT[127:64], V1_OUT[127:64]});

    // Randomised blocks with gaps, checked against the model and by round trip
    for (int i = 0; i < 200; i++) begin
      st  = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      run4(st, inv, $urandom_range(0, 3), res, lat);
      chk("rand_model", res, ref4(st, inv));
      run4(res, ~inv, 0, prev, lat);
      chk("rand_roundtrip", prev, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
